// File: rtl/ps2_keyboard_ascii.sv
// PS/2 keyboard receiver (scan code set 2) that turns make codes into ASCII
// characters, with arrow keys aliased to w/a/s/d.
module ps2_keyboard_ascii #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] asciiCode,
    output logic       asciiReady,
    output logic       frameError
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST    = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          armed_q, armed_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [8:0]    shreg_q, shreg_d;
    logic          rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
    state_t        state_q, state_d;
    logic          shift_q, shift_d;
    logic [7:0]    ascii_code_q, ascii_code_d;
    logic          ascii_ready_q, ascii_ready_d;
    logic          frame_error_q, frame_error_d;
    logic          sample_evt, timeout;
    logic [8:0]    lookup;

    // Returns {hit, character} for the unprefixed make codes.
    function automatic logic [8:0] map_make(input logic [7:0] code, input logic shifted);
        logic [8:0] res;
        logic [7:0] letter;
        res    = '0;
        letter = 8'h00;
        case (code)
            8'h1D: letter = 8'h77;
            8'h1C: letter = 8'h61;
            8'h1B: letter = 8'h73;
            8'h23: letter = 8'h64;
            8'h15: letter = 8'h71;
            8'h24: letter = 8'h65;
            8'h2D: letter = 8'h72;
            8'h2B: letter = 8'h66;
            8'h45: res = {1'b1, 8'h30};
            8'h16: res = {1'b1, 8'h31};
            8'h1E: res = {1'b1, 8'h32};
            8'h26: res = {1'b1, 8'h33};
            8'h25: res = {1'b1, 8'h34};
            8'h2E: res = {1'b1, 8'h35};
            8'h36: res = {1'b1, 8'h36};
            8'h3D: res = {1'b1, 8'h37};
            8'h3E: res = {1'b1, 8'h38};
            8'h46: res = {1'b1, 8'h39};
            8'h29: res = {1'b1, 8'h20};
            8'h5A: res = {1'b1, 8'h0D};
            8'h76: res = {1'b1, 8'h1B};
            8'h66: res = {1'b1, 8'h08};
            default: res = '0;
        endcase
        if (letter != 8'h00) begin
            res = {1'b1, shifted ? (letter - 8'h20) : letter};
        end
        return res;
    endfunction

    // Input conditioning, arming/timeout supervision and frame assembly.
    always_comb begin
        clk_meta_d = ps2Clk;
        clk_sync_d = clk_meta_q;
        dat_meta_d = ps2Data;
        dat_sync_d = dat_meta_q;
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        sample_evt = filt_q & ~filt_d;

        armed_d    = armed_q;
        idle_cnt_d = idle_cnt_q;
        timeout    = 1'b0;
        if (!armed_q) begin
            if (!filt_q) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == TIMEOUT_LAST) begin
                armed_d    = 1'b1;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end else if (sample_evt || bit_cnt_q == 4'd0) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q == TIMEOUT_LAST) begin
            timeout    = 1'b1;
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        if (timeout) begin
            bit_cnt_d = 4'd0;
            rx_err_d  = 1'b1;
        end else if (armed_q && sample_evt) begin
            if (bit_cnt_q == 4'd0) begin
                if (!dat_sync_q) begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                // shreg holds 8 data bits plus parity; odd parity XORs to 1
                if ((^shreg_q) && dat_sync_q) begin
                    rx_valid_d = 1'b1;
                end else begin
                    rx_err_d = 1'b1;
                end
            end else begin
                shreg_d   = {dat_sync_q, shreg_q[8:1]};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    // Prefix-tracking decoder run once per accepted byte.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        ascii_code_d  = ascii_code_q;
        ascii_ready_d = 1'b0;
        frame_error_d = rx_err_q;
        lookup        = map_make(shreg_q[7:0], shift_q);
        if (rx_err_q) begin
            state_d = IDLE;
        end else if (rx_valid_q) begin
            unique case (state_q)
                IDLE: begin
                    if (shreg_q[7:0] == 8'hF0) begin
                        state_d = BREAK;
                    end else if (shreg_q[7:0] == 8'hE0) begin
                        state_d = EXT;
                    end else if (shreg_q[7:0] == 8'h12 || shreg_q[7:0] == 8'h59) begin
                        shift_d = 1'b1;
                    end else if (lookup[8]) begin
                        ascii_code_d  = lookup[7:0];
                        ascii_ready_d = 1'b1;
                    end
                end
                BREAK: begin
                    if (shreg_q[7:0] == 8'h12 || shreg_q[7:0] == 8'h59) begin
                        shift_d = 1'b0;
                    end
                    state_d = IDLE;
                end
                EXT: begin
                    state_d = IDLE;
                    case (shreg_q[7:0])
                        8'hF0: state_d = EXT_BREAK;
                        8'h75: begin ascii_code_d = 8'h77; ascii_ready_d = 1'b1; end
                        8'h72: begin ascii_code_d = 8'h73; ascii_ready_d = 1'b1; end
                        8'h6B: begin ascii_code_d = 8'h61; ascii_ready_d = 1'b1; end
                        8'h74: begin ascii_code_d = 8'h64; ascii_ready_d = 1'b1; end
                        default: state_d = IDLE;
                    endcase
                end
                EXT_BREAK: state_d = IDLE;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_meta_q    <= 1'b1;
            clk_sync_q    <= 1'b1;
            dat_meta_q    <= 1'b1;
            dat_sync_q    <= 1'b1;
            filt_q        <= 1'b1;
            filt_cnt_q    <= '0;
            armed_q       <= 1'b0;
            idle_cnt_q    <= '0;
            bit_cnt_q     <= 4'd0;
            shreg_q       <= '0;
            rx_valid_q    <= 1'b0;
            rx_err_q      <= 1'b0;
            state_q       <= IDLE;
            shift_q       <= 1'b0;
            ascii_code_q  <= 8'h00;
            ascii_ready_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            clk_meta_q    <= clk_meta_d;
            clk_sync_q    <= clk_sync_d;
            dat_meta_q    <= dat_meta_d;
            dat_sync_q    <= dat_sync_d;
            filt_q        <= filt_d;
            filt_cnt_q    <= filt_cnt_d;
            armed_q       <= armed_d;
            idle_cnt_q    <= idle_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            rx_valid_q    <= rx_valid_d;
            rx_err_q      <= rx_err_d;
            state_q       <= state_d;
            shift_q       <= shift_d;
            ascii_code_q  <= ascii_code_d;
            ascii_ready_q <= ascii_ready_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign asciiCode  = ascii_code_q;
    assign asciiReady = ascii_ready_q;
    assign frameError = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// Bench for ps2_keyboard_ascii: directed key sequences followed by random frames,
// all scored against a byte-level keyboard model.
module tb_ps2_keyboard_ascii;
    localparam int TIMEOUT = 200;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2Clk  = 1'b1;
    logic       ps2Data = 1'b1;
    logic [7:0] asciiCode;
    logic       asciiReady;
    logic       frameError;

    int num_vectors     = 0;
    int num_miscompares = 0;
    int half_period     = 20;

    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];
    int err_seen  = 0;
    int err_exp   = 0;
    int both_seen = 0;

    bit mdl_shift = 1'b0;
    bit mdl_e0    = 1'b0;
    bit mdl_f0    = 1'b0;

    logic [7:0] letter_code[8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h15, 8'h24, 8'h2D, 8'h2B};
    logic [7:0] letter_char[8] = '{"w", "a", "s", "d", "q", "e", "r", "f"};
    logic [7:0] digit_code[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool[30] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h15, 8'h24, 8'h2D, 8'h2B,
                             8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                             8'h29, 8'h5A, 8'h76, 8'h66, 8'hF0, 8'hE0, 8'h12, 8'h59,
                             8'h75, 8'h72, 8'h6B, 8'h74};

    ps2_keyboard_ascii #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .asciiCode  (asciiCode),
        .asciiReady (asciiReady),
        .frameError (frameError)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (asciiReady) obs_q.push_back(asciiCode);
        if (frameError) err_seen++;
        if (asciiReady && frameError) both_seen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        num_vectors++;
        if (observed !== expected) begin
            num_miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Character for an unprefixed make code, or -1 when the key is unmapped.
    function automatic int lookup_char(input logic [7:0] code, input bit shifted);
        for (int i = 0; i < 8; i++)
            if (code == letter_code[i]) return shifted ? int'(letter_char[i]) - 32 : int'(letter_char[i]);
        for (int i = 0; i < 10; i++)
            if (code == digit_code[i]) return 48 + i;
        if (code == 8'h29) return 32;
        if (code == 8'h5A) return 13;
        if (code == 8'h76) return 27;
        if (code == 8'h66) return 8;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] code);
        int c;
        if (mdl_f0) begin
            if (!mdl_e0 && (code == 8'h12 || code == 8'h59)) mdl_shift = 1'b0;
            mdl_f0 = 1'b0;
            mdl_e0 = 1'b0;
        end else if (mdl_e0) begin
            if (code == 8'hF0) begin
                mdl_f0 = 1'b1;
            end else begin
                mdl_e0 = 1'b0;
                if (code == 8'h75) exp_q.push_back("w");
                if (code == 8'h72) exp_q.push_back("s");
                if (code == 8'h6B) exp_q.push_back("a");
                if (code == 8'h74) exp_q.push_back("d");
            end
        end else if (code == 8'hF0) begin
            mdl_f0 = 1'b1;
        end else if (code == 8'hE0) begin
            mdl_e0 = 1'b1;
        end else if (code == 8'h12 || code == 8'h59) begin
            mdl_shift = 1'b1;
        end else begin
            c = lookup_char(code, mdl_shift);
            if (c >= 0) exp_q.push_back(8'(c));
        end
    endtask

    task automatic model_error();
        err_exp++;
        mdl_e0 = 1'b0;
        mdl_f0 = 1'b0;
    endtask

    // Drives bits first_bit..last_bit of one frame; the device samples on clock falls.
    task automatic applyStimulus(input logic [7:0] code, input bit bad_parity, input bit bad_stop,
                                 input int first_bit, input int last_bit);
        logic [10:0] bits;
        bits = {~bad_stop, (~^code) ^ bad_parity, code, 1'b0};
        for (int i = first_bit; i <= last_bit; i++) begin
            @(negedge clock);
            ps2Data = bits[i];
            repeat (half_period) @(negedge clock);
            ps2Clk = 1'b0;
            repeat (half_period) @(negedge clock);
            ps2Clk = 1'b1;
        end
        @(negedge clock);
        ps2Data = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] code, input bit bad_parity, input bit bad_stop);
        applyStimulus(code, bad_parity, bad_stop, 0, 10);
        if (bad_parity || bad_stop) model_error();
        else model_byte(code);
    endtask

    task automatic settle_and_check(input string tag);
        repeat (30) @(negedge clock);
        checkOutput({tag, " pulses"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            checkOutput({tag, " code"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
        checkOutput({tag, " frameError"}, err_seen, err_exp);
        err_seen = 0;
        err_exp  = 0;
    endtask

    initial begin
        logic [7:0] code;
        int pick;
        bit bp, bs;

        reset = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("reset asciiCode", asciiCode, 0);
        checkOutput("reset asciiReady", asciiReady, 0);
        checkOutput("reset frameError", frameError, 0);
        reset = 1'b0;

        // Frames before the first idle gap must be ignored.
        applyStimulus(8'h1D, 1'b0, 1'b0, 0, 10);
        settle_and_check("disarmed");
        repeat (TIMEOUT + 50) @(negedge clock);

        send_byte(8'h1D, 0, 0);
        settle_and_check("make w");
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1D, 0, 0);
        settle_and_check("break w");

        send_byte(8'h12, 0, 0);
        send_byte(8'h1C, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h1C, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h12, 0, 0);
        send_byte(8'h1C, 0, 0);
        settle_and_check("shift A then a");

        send_byte(8'hE0, 0, 0);
        send_byte(8'h6B, 0, 0);
        settle_and_check("arrow left");
        send_byte(8'hE0, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h6B, 0, 0);
        settle_and_check("arrow release");
        send_byte(8'h1D, 0, 0);
        settle_and_check("idle after ext break");

        send_byte(8'h1B, 1, 0);
        settle_and_check("bad parity");
        send_byte(8'h1B, 0, 0);
        settle_and_check("good s");
        send_byte(8'h23, 0, 1);
        settle_and_check("bad stop");
        send_byte(8'h23, 0, 0);
        settle_and_check("good d");

        applyStimulus(8'h29, 1'b0, 1'b0, 0, 4);
        repeat (TIMEOUT + 100) @(negedge clock);
        model_error();
        settle_and_check("stall timeout");
        send_byte(8'h29, 0, 0);
        settle_and_check("space after timeout");

        applyStimulus(8'h45, 1'b0, 1'b0, 0, 3);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        mdl_shift = 1'b0;
        mdl_e0    = 1'b0;
        mdl_f0    = 1'b0;
        applyStimulus(8'h45, 1'b0, 1'b0, 4, 10);
        settle_and_check("reset mid-frame");
        repeat (TIMEOUT + 50) @(negedge clock);
        send_byte(8'h45, 0, 0);
        settle_and_check("digit 0 after rearm");

        for (int n = 0; n < 40; n++) begin
            half_period = $urandom_range(12, 24);
            pick = $urandom_range(0, 30);
            code = (pick == 30) ? 8'($urandom) : pool[pick];
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 19) == 0);
            send_byte(code, bp, bs);
            settle_and_check($sformatf("random%0d", n));
        end

        checkOutput("ready with error", both_seen, 0);
        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_ascii.md
# ps2_keyboard_ascii

Receives a PS/2 keyboard (scan code set 2) on the raw `ps2Clk`/`ps2Data` lines and decodes make codes into ASCII. Each accepted keypress produces a one-cycle `asciiReady` pulse with `asciiCode` valid. This is the producer side of the `asciiCode`/`asciiReady` interface consumed by the raycaster player-control logic. Arrow keys alias to `w`/`a`/`s`/`d`.

## Interface
- `FILTER_LEN`, default 4: consecutive equal samples required before the filtered `ps2Clk` level changes.
- `TIMEOUT_CYCLES`, default 50000: idle-gap length in `clock` cycles. It aborts a stalled frame and arms the receiver after reset.
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high; clock `clock`.
- `ps2Clk`  in  1  raw PS/2 clock from the keyboard; asynchronous; idle high.
- `ps2Data`  in  1  raw PS/2 data from the keyboard; asynchronous; idle high.
- `asciiCode`  out  8  last decoded ASCII character; holds until the next decode.
- `asciiReady`  out  1  one-cycle pulse; `asciiCode` is valid in that same cycle.
- `frameError`  out  1  one-cycle pulse on a parity error, a bad stop bit, or a mid-frame timeout.

## Operation
- **Input conditioning**
  - `ps2Clk` and `ps2Data` each pass through a 2-flop synchronizer.
  - The synchronized `ps2Clk` feeds a saturating filter: the filtered level flips only after `FILTER_LEN` consecutive samples at the new level.
  - A filtered high-to-low transition is a sample event. At that event the synchronized `ps2Data` is captured.
- **Arming**
  - After reset the receiver is disarmed and ignores sample events.
  - It arms once filtered `ps2Clk` has stayed high for `TIMEOUT_CYCLES` consecutive cycles. This recovers cleanly when reset lands mid-frame.
- **Frame**
  - 11 bits: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1). A 4-bit counter tracks the position 0..10.
  - A start sample of 1 is ignored; the counter stays at 0.
  - The byte is accepted only if the XOR of the data bits and the parity bit is 1 and the stop bit is 1. Otherwise the byte is dropped, `frameError` pulses, and the decoder returns to IDLE.
- **Timeout**
  - While the counter is nonzero, an idle counter counts cycles since the last sample event.
  - When it reaches `TIMEOUT_CYCLES`, the counter clears and `frameError` pulses once. The decoder FSM returns to IDLE and the shift state is kept.
- **Decoder FSM** (states IDLE, BREAK, EXT, EXT_BREAK), on each accepted byte:
  - IDLE:
    - 0xF0 -> BREAK.
    - 0xE0 -> EXT.
    - 0x12 or 0x59 -> set shift.
    - Mapped code -> emit character.
    - Anything else -> ignored.
  - BREAK: 0x12 or 0x59 clears shift; any byte -> IDLE; no emit.
  - EXT: 0xF0 -> EXT_BREAK.
  - EXT: 0x75 emits `w`, 0x72 emits `s`, 0x6B emits `a`, 0x74 emits `d`, then -> IDLE. Shift is ignored for these. Other bytes -> IDLE.
  - EXT_BREAK: any byte -> IDLE; no emit.
- **Make-code map**
  - Letters (lowercase; uppercase when shift is set, i.e. code minus 0x20):
    - W=0x1D, A=0x1C, S=0x1B, D=0x23
    - Q=0x15, E=0x24, R=0x2D, F=0x2B
  - Digits 0–9 (shift ignored): 0x45, 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46.
  - Other keys:
    - Space 0x29 -> 0x20.
    - Enter 0x5A -> 0x0D.
    - Esc 0x76 -> 0x1B.
    - Backspace 0x66 -> 0x08.
- **Typematic repeat**: each repeated make code is decoded and emits a new pulse; there is no debounce on repeats.

## Timing
- Reset values:
  - `asciiCode` = 0x00, `asciiReady` = 0, `frameError` = 0.
  - FSM = IDLE, shift = 0, bit counter = 0, disarmed.
  - Synchronizer flops and the filtered clock = 1.
- Sample-event latency: a `ps2Clk` fall reaches the filtered level 2 + `FILTER_LEN` cycles after the raw fall.
- Emit latency: if the stop bit is captured at edge k, the decode is performed and `asciiReady`/`asciiCode` update at edge k+1.
- Pulse shape: `asciiReady` is high for exactly 1 cycle per emitted character. `frameError` and `asciiReady` never assert together.
- Supported PS/2 rate: 10–16.7 kHz. The `clock` period × (`FILTER_LEN` + 2) must be much shorter than the 30 µs PS/2 clock half-period.
- Reset mid-frame: all state returns to the reset values. A partial frame never produces `asciiReady`.

## Test plan
For simulation, use `TIMEOUT_CYCLES` = 200 and `FILTER_LEN` = 4. Arm the receiver with an idle gap of at least 200 cycles after reset.

- Frame 0x1D with correct odd parity -> one `asciiReady` pulse, `asciiCode` = 0x77 (`w`); then frames F0, 1D -> no pulse.
- Frames 12, 1C, F0 1C, F0 12, 1C -> pulses with 0x41 then 0x61; shift is clear at the end.
- Frames E0 6B -> `asciiCode` = 0x61; frames E0 F0 6B -> no pulse, FSM back in IDLE.
- Frame 0x1B with a wrong parity bit -> `frameError` pulses once, no `asciiReady`; a following good 0x1B -> 0x73.
- Stop clocking after 5 bits, wait 200 cycles -> `frameError` pulses once; a subsequent full 0x29 frame -> 0x20.
- Assert reset after bit 4 of a frame, then continue the remaining bits -> no output; after a 200-cycle gap, frame 0x45 -> 0x30.
